// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential ROM reads and buffers {pc, inst}
// pairs in a small FIFO, with redirect flush and stop (halt) support.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              QDEPTH   = 4,
  parameter int              IMEM_AW  = 14,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stop,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic               out_valid,
  output logic [XLEN-1:0]    out_inst,
  output logic [XLEN-1:0]    out_pc,
  input  logic               out_ready,
  output logic               misalign
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  entry_t [QDEPTH-1:0] mem;
  logic [XLEN-1:0]     fetch_pc;
  logic [XLEN-1:0]     tag;
  logic                inflight;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic [CW:0]         occ;
  logic                issue, push, pop;

  // Occupancy includes the outstanding read so the FIFO can never overflow.
  assign occ   = (CW+1)'(count) + (CW+1)'(inflight);
  assign issue = rst_n && !stop && !redirect_valid && (occ < (CW+1)'(QDEPTH));
  assign push  = inflight && !redirect_valid;
  assign pop   = out_valid && out_ready;

  assign imem_en   = issue;
  assign imem_addr = fetch_pc[IMEM_AW+1:2];
  assign misalign  = rst_n && redirect_valid && (redirect_pc[1:0] != 2'b00);

  assign out_valid = (count != '0);
  assign out_inst  = mem[rd_ptr].inst;
  assign out_pc    = mem[rd_ptr].pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      tag      <= '0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      // Flush drops queued entries, any same-cycle pop, and the returning read.
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + XLEN'(4);
        tag      <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; count gates visibility of every slot.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: tag, inst: imem_rdata};
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: ROM word n holds n, checks at negedge + 1.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stop = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_en;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;
  logic        misalign;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_queue #(.XLEN(32), .QDEPTH(4), .IMEM_AW(14), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stop(stop),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_ready(out_ready), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one cycle read latency.
  always @(posedge clk) if (imem_en) imem_rdata <= 32'(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cnt;
    // Reset state
    repeat (2) nx();
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_en", imem_en, 0);
    chk("rst_mis", misalign, 0);
    chk("rst_addr", imem_addr, 0);

    // Release with consumer stalled: exactly four fetches fill the queue
    nx(); rst_n = 1'b1; #1;
    chk("rel_en", imem_en, 1);
    chk("rel_addr", imem_addr, 0);
    en_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_en) en_cnt++;
      nx(); #1;
    end
    chk("bp_issues", en_cnt, 4);
    chk("bp_valid", out_valid, 1);
    chk("bp_pc", out_pc, 0);
    chk("bp_inst", out_inst, 0);
    chk("bp_en", imem_en, 0);
    chk("bp_addr", imem_addr, 4);

    // Drain and stream one per cycle
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("stream_pc%0d", k), out_pc, 32'(4 * k));
      chk($sformatf("stream_inst%0d", k), out_inst, 32'(k));
      chk($sformatf("stream_v%0d", k), out_valid, 1);
      nx(); #1;
    end

    // Build count=3 plus an inflight read, then redirect to 0x100
    out_ready = 1'b0;
    nx(); #1;
    chk("pre_rd_pc", out_pc, 32'h20);
    redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    chk("rd_en", imem_en, 0);
    chk("rd_mis", misalign, 0);
    nx(); redirect_valid = 1'b0; #1;
    chk("rd_flush", out_valid, 0);
    chk("rd_en1", imem_en, 1);
    chk("rd_addr", imem_addr, 14'h40);
    nx(); #1;
    chk("rd_v2", out_valid, 0);
    nx(); out_ready = 1'b1; #1;
    chk("rd_v3", out_valid, 1);
    chk("rd_pc0", out_pc, 32'h100);
    chk("rd_inst0", out_inst, 32'h40);
    nx(); #1;
    chk("rd_pc1", out_pc, 32'h104);
    chk("rd_inst1", out_inst, 32'h41);
    nx(); #1;
    chk("rd_pc2", out_pc, 32'h108);

    // Fill from 0x10 so fetch_pc parks at 0x20, then stop for 5 cycles
    redirect_valid = 1'b1; redirect_pc = 32'h10; out_ready = 1'b0;
    nx(); redirect_valid = 1'b0;
    repeat (8) nx();
    #1;
    chk("st_full_pc", out_pc, 32'h10);
    chk("st_full_en", imem_en, 0);
    chk("st_full_addr", imem_addr, 8);
    stop = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("st_en%0d", i), imem_en, 0);
      if (i < 4) begin
        chk($sformatf("st_pc%0d", i), out_pc, 32'(32'h10 + 4 * i));
        chk($sformatf("st_inst%0d", i), out_inst, 32'(4 + i));
      end else begin
        chk("st_empty", out_valid, 0);
      end
      nx();
    end
    stop = 1'b0; #1;
    chk("st_res_en", imem_en, 1);
    chk("st_res_addr", imem_addr, 8);
    nx(); #1;
    chk("st_res_v", out_valid, 0);
    nx(); #1;
    chk("st_res_pc", out_pc, 32'h20);
    chk("st_res_inst", out_inst, 8);
    nx(); #1;
    chk("st_res_pc1", out_pc, 32'h24);

    // Misaligned redirect with a pop in the same cycle
    chk("mis_pre_v", out_valid, 1);
    redirect_valid = 1'b1; redirect_pc = 32'h102; #1;
    chk("mis_pulse", misalign, 1);
    nx(); redirect_valid = 1'b0; #1;
    chk("mis_clear", misalign, 0);
    chk("mis_empty", out_valid, 0);
    chk("mis_addr", imem_addr, 14'h40);
    nx(); #1;
    chk("mis_v2", out_valid, 0);
    nx(); #1;
    chk("mis_pc", out_pc, 32'h100);
    chk("mis_inst", out_inst, 32'h40);

    // Reset mid-stream with three entries queued
    out_ready = 1'b0;
    nx(); nx(); #1;
    chk("mr_pre_v", out_valid, 1);
    rst_n = 1'b0; #1;
    chk("mr_v", out_valid, 0);
    chk("mr_en", imem_en, 0);
    chk("mr_addr", imem_addr, 0);
    nx(); nx(); rst_n = 1'b1; out_ready = 1'b1; #1;
    chk("mr_rel_en", imem_en, 1);
    chk("mr_rel_addr", imem_addr, 0);
    nx(); #1;
    chk("mr_v1", out_valid, 0);
    for (int k = 0; k < 3; k++) begin
      nx(); #1;
      chk($sformatf("mr_pc%0d", k), out_pc, 32'(4 * k));
      chk($sformatf("mr_inst%0d", k), out_inst, 32'(k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
